// File: rtl/activ_stage_scheduler.sv
// -----------------------------------------------------------------------------
// activ_stage_scheduler
//
// Purpose:
//   Round-robin scheduler that shares a single activation-function stage among
//   N neuron accumulators. At most one operation is issued per clock. Every
//   issued operation is tracked through the stage latency, and its completion
//   is reported back with the id of the requester that issued it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   req        per-requester request level, held with its data until granted
//   req_val    requester i value in bits [16i+15:16i]
//   req_sel    requester i function select in bits [2i+1:2i]
//   req_dest   requester i destination in bits [16i+15:16i]
//   stall      downstream write port busy; suppresses new issues
//   gnt        one-hot grant pulse, coincident with stg_we
//   stg_val    registered value to the stage
//   stg_sel    registered function select to the stage
//   stg_dest   registered destination to the stage
//   stg_we     registered issue strobe to the stage
//   done_vld   one-cycle pulse when an issued operation completes
//   done_id    requester id of the completing operation
//   busy       high while any request is pending or any operation is in flight
//   issue_cnt  total issues since reset (wraps at 16 bits)
// -----------------------------------------------------------------------------
module activ_stage_scheduler #(
   parameter int N         = 4,
   parameter int IDW       = 2,
   parameter int STAGE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req,
   input  logic [16*N-1:0]   req_val,
   input  logic [2*N-1:0]    req_sel,
   input  logic [16*N-1:0]   req_dest,
   input  logic              stall,
   output logic [N-1:0]      gnt,
   output logic [15:0]       stg_val,
   output logic [1:0]        stg_sel,
   output logic [15:0]       stg_dest,
   output logic              stg_we,
   output logic              done_vld,
   output logic [IDW-1:0]    done_id,
   output logic              busy,
   output logic [15:0]       issue_cnt
);

   localparam logic [IDW:0] N_EXT = (IDW+1)'(N);

   // Modulo-N addition of two requester indices. One extra bit holds the
   // carry so the single conditional subtract is enough for any base, offset
   // below N.
   function automatic logic [IDW-1:0] addMod(input logic [IDW-1:0] base,
                                             input logic [IDW-1:0] offset);
      logic [IDW:0] sum;
      sum = {1'b0, base} + {1'b0, offset};
      if (sum >= N_EXT) begin
         sum = sum - N_EXT;
      end
      return sum[IDW-1:0];
   endfunction

   logic [IDW-1:0]       ptr;
   logic [N-1:0]         eligible;
   logic                 winFound;
   logic [IDW-1:0]       winId;
   logic [N-1:0]         winOneHot;
   logic [15:0]          winVal;
   logic [1:0]           winSel;
   logic [15:0]          winDest;
   logic                 issueEn;

   logic [IDW-1:0]       stgId_p1;
   logic [STAGE_LAT-1:0] trkVld_p2;
   logic [IDW-1:0]       trkId_p2 [STAGE_LAT];

   // The requester granted this cycle still shows req high; it is masked so
   // the same request is never issued twice.
   assign eligible = req & ~gnt;

   // Search ptr, ptr+1, ... (mod N); the first eligible index wins.
   always_comb begin
      logic [IDW-1:0] cand;
      winFound = 1'b0;
      winId    = '0;
      cand     = '0;
      for (int k = 0; k < N; k++) begin
         cand = addMod(ptr, IDW'(k));
         if (!winFound && eligible[cand]) begin
            winFound = 1'b1;
            winId    = cand;
         end
      end
   end

   always_comb begin
      winOneHot        = '0;
      winOneHot[winId] = winFound;
      winVal           = req_val[int'(winId)*16 +: 16];
      winSel           = req_sel[int'(winId)*2 +: 2];
      winDest          = req_dest[int'(winId)*16 +: 16];
   end

   assign issueEn = winFound & ~stall;

   // ---- stage p1: issue register into the activation stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt       <= '0;
         stg_we    <= 1'b0;
         stg_val   <= '0;
         stg_sel   <= '0;
         stg_dest  <= '0;
         stgId_p1  <= '0;
         ptr       <= '0;
         issue_cnt <= '0;
      end else if (issueEn) begin
         gnt       <= winOneHot;
         stg_we    <= 1'b1;
         stg_val   <= winVal;
         stg_sel   <= winSel;
         stg_dest  <= winDest;
         stgId_p1  <= winId;
         ptr       <= addMod(winId, IDW'(1));
         issue_cnt <= issue_cnt + 16'd1;
      end else begin
         // Stage data holds its last value; only the strobes drop.
         gnt       <= '0;
         stg_we    <= 1'b0;
      end
   end

   // ---- stage p2: completion tracker, one slot per clock of stage latency ----
   // The tracker never freezes: once issued, an operation always completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trkVld_p2 <= '0;
         for (int k = 0; k < STAGE_LAT; k++) begin
            trkId_p2[k] <= '0;
         end
      end else begin
         trkVld_p2[0] <= stg_we;
         trkId_p2[0]  <= stg_we ? stgId_p1 : '0;
         for (int k = 1; k < STAGE_LAT; k++) begin
            trkVld_p2[k] <= trkVld_p2[k-1];
            trkId_p2[k]  <= trkId_p2[k-1];
         end
      end
   end

   assign done_vld = trkVld_p2[STAGE_LAT-1];
   assign done_id  = trkId_p2[STAGE_LAT-1];

   assign busy = (|req) | stg_we | (|trkVld_p2);

endmodule
